// File: rtl/dht_responder_if.sv
// Payload and status bundle for dht_responder; the single-wire bus itself stays a plain inout.
// DHT_RESP_FAULT_EN adds fault_inj to the bundle.
interface dht_responder_if;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
`ifdef DHT_RESP_FAULT_EN
    logic       fault_inj;
`endif
    logic       busy;
    logic       frame_done;

`ifdef DHT_RESP_FAULT_EN
    modport master (
        output hum_int, hum_dec, tmp_int, tmp_dec, fault_inj,
        input  busy, frame_done
    );

    modport slave (
        input  hum_int, hum_dec, tmp_int, tmp_dec, fault_inj,
        output busy, frame_done
    );
`else
    modport master (
        output hum_int, hum_dec, tmp_int, tmp_dec,
        input  busy, frame_done
    );

    modport slave (
        input  hum_int, hum_dec, tmp_int, tmp_dec,
        output busy, frame_done
    );
`endif
endinterface

// File: rtl/dht_responder.sv
// DHT11-style single-wire responder: answers a host start pulse with preamble and a 40-bit frame.
// Optional DHT_RESP_FAULT_EN: bus.fault_inj sampled at latch inverts the transmitted checksum.
module dht_responder #(
    parameter int unsigned TICK_CNT     = 1000,
    parameter int unsigned START_MIN_US = 1000,
    parameter int unsigned RESP_DLY_US  = 30,
    parameter int unsigned RESP_LOW_US  = 80,
    parameter int unsigned RESP_HIGH_US = 80,
    parameter int unsigned BIT_LOW_US   = 50,
    parameter int unsigned BIT0_HIGH_US = 26,
    parameter int unsigned BIT1_HIGH_US = 70,
    parameter int unsigned STOP_LOW_US  = 50
) (
    input  logic           clk,
    input  logic           rst,
    inout  wire            dht,
    dht_responder_if.slave bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned UsSat = max2(max2(max2(START_MIN_US, RESP_DLY_US),
                                              max2(RESP_LOW_US, RESP_HIGH_US)),
                                         max2(max2(BIT_LOW_US, BIT0_HIGH_US),
                                              max2(BIT1_HIGH_US, STOP_LOW_US)));
    localparam int unsigned UsW   = $clog2(UsSat + 1);
    localparam int unsigned CycW  = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StHostLow  = 3'd1;
    localparam logic [2:0] StRespDly  = 3'd2;
    localparam logic [2:0] StRespLow  = 3'd3;
    localparam logic [2:0] StRespHigh = 3'd4;
    localparam logic [2:0] StBitLow   = 3'd5;
    localparam logic [2:0] StBitHigh  = 3'd6;
    localparam logic [2:0] StStopLow  = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [UsW-1:0]  us_q, us_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic [39:0]     frame_q;
    logic            done_q, done_d;
    logic            dht_meta_q, dht_sync_q;

    logic            latch;
    logic            tick_wrap;
    logic            phase_end;
    logic [UsW-1:0]  phase_us;
    logic            cur_bit;
    logic [7:0]      chk;
    logic [7:0]      chk_tx;
    logic            drive_low;

    // Bus idles high through the pull-up, so the synchronizer resets to 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dht_meta_q <= 1'b1;
            dht_sync_q <= 1'b1;
        end else begin
            dht_meta_q <= dht;
            dht_sync_q <= dht_meta_q;
        end
    end

    assign chk = bus.hum_int + bus.hum_dec + bus.tmp_int + bus.tmp_dec;

`ifdef DHT_RESP_FAULT_EN
    assign chk_tx = chk ^ {8{bus.fault_inj}};
`else
    assign chk_tx = chk;
`endif

    assign cur_bit   = frame_q[bit_idx_q];
    assign tick_wrap = (cyc_q == CycW'(TICK_CNT - 1));

    always_comb begin
        phase_us = '0;
        case (state_q)
            StRespDly:  phase_us = UsW'(RESP_DLY_US);
            StRespLow:  phase_us = UsW'(RESP_LOW_US);
            StRespHigh: phase_us = UsW'(RESP_HIGH_US);
            StBitLow:   phase_us = UsW'(BIT_LOW_US);
            StBitHigh:  phase_us = cur_bit ? UsW'(BIT1_HIGH_US) : UsW'(BIT0_HIGH_US);
            StStopLow:  phase_us = UsW'(STOP_LOW_US);
            default:    phase_us = '0;
        endcase
    end

    assign phase_end = tick_wrap && (us_q == phase_us - UsW'(1));

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        latch     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!dht_sync_q) state_d = StHostLow;
            end
            StHostLow: begin
                if (dht_sync_q) begin
                    if (us_q >= UsW'(START_MIN_US)) begin
                        state_d = StRespDly;
                        latch   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespDly: begin
                if (phase_end) state_d = StRespLow;
            end
            StRespLow: begin
                if (phase_end) state_d = StRespHigh;
            end
            StRespHigh: begin
                if (phase_end) begin
                    state_d   = StBitLow;
                    bit_idx_d = 6'd39;
                end
            end
            StBitLow: begin
                if (phase_end) state_d = StBitHigh;
            end
            StBitHigh: begin
                if (phase_end) begin
                    if (bit_idx_q == 6'd0) begin
                        state_d = StStopLow;
                    end else begin
                        state_d   = StBitLow;
                        bit_idx_d = bit_idx_q - 6'd1;
                    end
                end
            end
            StStopLow: begin
                if (phase_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters restart on every state change; us count saturates so long host lows cannot wrap.
    always_comb begin
        cyc_d = cyc_q;
        us_d  = us_q;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            cyc_d = '0;
            us_d  = '0;
        end else if (tick_wrap) begin
            cyc_d = '0;
            if (us_q < UsW'(UsSat)) us_d = us_q + UsW'(1);
        end else begin
            cyc_d = cyc_q + CycW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            us_q      <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            us_q      <= us_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_q <= '0;
        end else if (latch) begin
            frame_q <= {bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec, chk_tx};
        end
    end

    assign drive_low = (state_q == StRespLow) || (state_q == StBitLow) ||
                       (state_q == StStopLow);
    assign dht       = drive_low ? 1'b0 : 1'bz;

    assign bus.busy       = (state_q != StIdle) && (state_q != StHostLow);
    assign bus.frame_done = done_q;

`ifndef SYNTHESIS
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst)
        bus.frame_done |-> !bus.busy);
    a_bit_idx_range: assert property (@(posedge clk) disable iff (!rst)
        bit_idx_q <= 6'd39);
`endif

endmodule

// File: tb/tb_dht_responder.sv
// Self-checking bench for dht_responder: host start pulses, frame decode against a scoreboard.
module tb_dht_responder;

    localparam int T        = 4;
    localparam int START_US = 100;
    localparam int RESP_CLK = 80 * T;
    localparam int BLOW_CLK = 50 * T;
    localparam int B0_CLK   = 26 * T;
    localparam int B1_CLK   = 70 * T;
    localparam int STOP_CLK = 50 * T;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic host_low = 1'b0;
    wire  dht;

    pullup (dht);
    assign dht = host_low ? 1'b0 : 1'bz;

    dht_responder_if bus ();

    dht_responder #(
        .TICK_CNT     (T),
        .START_MIN_US (START_US)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dht (dht),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [39:0] exp_q[$];

    always @(posedge clk) if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running at %0t, limit 950000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic f);
        bus.hum_int = a;
        bus.hum_dec = b;
        bus.tmp_int = c;
        bus.tmp_dec = d;
`ifdef DHT_RESP_FAULT_EN
        bus.fault_inj = f;
`else
        if (f) bus.hum_int = a;
`endif
    endtask

    task automatic host_start(input int us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (us * T) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_bus(input logic level, input int limit, output int cycles, output int to);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (dht !== level && cycles < limit);
        to = (dht !== level) ? 1 : 0;
    endtask

    // Measures one response frame; chg_bit re-drives inputs at that bit, abort_bit stops early.
    task automatic rx_frame(input int chg_bit, input int abort_bit, output logic [39:0] data,
                            output int dly, output int werr, output int tmo,
                            output bit done_e, output bit busy_e, output bit aborted);
        int c, to;
        logic b;
        data = '0; werr = 0; tmo = 0; done_e = 0; busy_e = 1; aborted = 0;
        wait_bus(1'b0, 400, dly, to);   tmo += to; if (tmo != 0) return;
        wait_bus(1'b1, 400, c, to);     tmo += to; if (tmo != 0) return;
        if (c != RESP_CLK) werr++;
        wait_bus(1'b0, 400, c, to);     tmo += to; if (tmo != 0) return;
        if (c != RESP_CLK) werr++;
        for (int i = 39; i >= 0; i--) begin
            if (i == chg_bit) set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0);
            wait_bus(1'b1, 400, c, to); tmo += to; if (tmo != 0) return;
            if (c != BLOW_CLK) werr++;
            if (i == abort_bit) begin
                aborted = 1;
                return;
            end
            wait_bus(1'b0, 400, c, to); tmo += to; if (tmo != 0) return;
            b = (c > (B0_CLK + B1_CLK) / 2);
            if (c != (b ? B1_CLK : B0_CLK)) werr++;
            data[i] = b;
        end
        wait_bus(1'b1, 400, c, to);     tmo += to; if (tmo != 0) return;
        if (c != STOP_CLK) werr++;
        done_e = bus.frame_done;
        busy_e = bus.busy;
    endtask

    task automatic test_reset();
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, want 0", bus.busy);
        end
        n_checks++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b, want 0", bus.frame_done);
        end
        n_checks++;
        if (dht !== 1'b1) begin
            n_fail++; $display("FAIL reset_dht_released: got %b, want 1 (pull-up)", dht);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_normal_frame();
        logic [39:0] got, exp;
        int dly, werr, tmo, d0;
        bit done_e, busy_e, ab;
        set_inputs(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        d0 = done_cnt;
        host_start(120);
        exp_q.push_back(40'h37_00_19_05_55);
        rx_frame(-1, -1, got, dly, werr, tmo, done_e, busy_e, ab);
        exp = exp_q.pop_front();
        n_checks++;
        if (tmo != 0) begin n_fail++; $display("FAIL normal_timeout: got %0d, want 0", tmo); end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL normal_frame: got %h, want %h", got, exp);
        end
        n_checks++;
        if (dly < 30 * T + 2 || dly > 30 * T + 4) begin
            n_fail++; $display("FAIL normal_resp_delay: got %0d clk, want %0d+/-1", dly, 30 * T + 3);
        end
        n_checks++;
        if (werr != 0) begin
            n_fail++; $display("FAIL normal_widths: got %0d bad phases, want 0", werr);
        end
        n_checks++;
        if (done_e !== 1'b1) begin
            n_fail++; $display("FAIL normal_done_at_release: got %b, want 1", done_e);
        end
        n_checks++;
        if (busy_e !== 1'b0) begin
            n_fail++; $display("FAIL normal_busy_at_release: got %b, want 0", busy_e);
        end
        @(negedge clk);
        n_checks++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL normal_done_pulse_width: got %b, want 0", bus.frame_done);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL normal_done_count: got %0d, want 1", done_cnt - d0);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL normal_busy_after: got %b, want 0", bus.busy);
        end
        repeat (20) @(negedge clk);
    endtask

    // Checksum wrap frame; inputs are scrambled at bit 30 and must not reach the frame.
    task automatic test_wrap_input_change();
        logic [39:0] got, exp;
        int dly, werr, tmo;
        bit done_e, busy_e, ab;
        set_inputs(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
        host_start(120);
        exp_q.push_back(40'hFF_FF_01_02_01);
        rx_frame(30, -1, got, dly, werr, tmo, done_e, busy_e, ab);
        exp = exp_q.pop_front();
        n_checks++;
        if (tmo != 0) begin n_fail++; $display("FAIL wrap_timeout: got %0d, want 0", tmo); end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL wrap_frame: got %h, want %h", got, exp);
        end
        n_checks++;
        if (got[7:0] !== 8'h01) begin
            n_fail++; $display("FAIL wrap_chk: got %h, want 01", got[7:0]);
        end
        n_checks++;
        if (werr != 0) begin
            n_fail++; $display("FAIL wrap_widths: got %0d bad phases, want 0", werr);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_short_start();
        int bad, d0;
        set_inputs(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        d0  = done_cnt;
        bad = 0;
        host_start(50);
        repeat (1500) begin
            @(negedge clk);
            if (dht !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL short_start_idle: got %0d active cycles, want 0", bad);
        end
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++; $display("FAIL short_start_done: got %0d pulses, want 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] got, exp;
        int dly, werr, tmo, bad;
        bit done_e, busy_e, ab;
        set_inputs(8'h5A, 8'hC3, 8'h0F, 8'hF0, 1'b0);
        host_start(120);
        rx_frame(-1, 37, got, dly, werr, tmo, done_e, busy_e, ab);
        n_checks++;
        if (ab !== 1'b1 || tmo != 0) begin
            n_fail++; $display("FAIL rstmid_reach_bit: got aborted=%b tmo=%0d, want 1/0", ab, tmo);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_busy: got %b, want 0", bus.busy);
        end
        n_checks++;
        if (dht !== 1'b1 || bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got dht=%b done=%b, want 1/0", dht,
                               bus.frame_done);
        end
        rst = 1'b1;
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (dht !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_stays_idle: got %0d active cycles, want 0", bad);
        end

        set_inputs(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        host_start(120);
        exp_q.push_back(40'h12_34_56_78_14);
        rx_frame(-1, -1, got, dly, werr, tmo, done_e, busy_e, ab);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || tmo != 0) begin
            n_fail++; $display("FAIL rstmid_next_frame: got %h tmo=%0d, want %h", got, tmo, exp);
        end
        n_checks++;
        if (werr != 0 || done_e !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_next_timing: got werr=%0d done=%b, want 0/1", werr,
                               done_e);
        end
        repeat (20) @(negedge clk);
    endtask

`ifdef DHT_RESP_FAULT_EN
    task automatic test_fault();
        logic [39:0] got, exp;
        int dly, werr, tmo;
        bit done_e, busy_e, ab;
        set_inputs(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        host_start(120);
        exp_q.push_back(40'h37_00_19_05_AA);
        rx_frame(-1, -1, got, dly, werr, tmo, done_e, busy_e, ab);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || tmo != 0) begin
            n_fail++; $display("FAIL fault_frame: got %h tmo=%0d, want %h", got, tmo, exp);
        end
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_normal_frame();
        test_wrap_input_change();
        test_short_start();
        test_reset_mid_frame();
`ifdef DHT_RESP_FAULT_EN
        test_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
